mult_req_issuer: RTL and testbench
==================================

Name: mult_req_issuer

Overview:
- Initiator-side block for the 4-bit repeated-addition multiplier protocol (start, data_in, result, done).
- Accepts operand pairs on a valid/ready request port and serialises each pair onto the multiplier's start/data_in lines.
- Waits for done, captures result, and returns product plus status on a valid/ready response port.
- Sits between the test/host logic and the multiplier DUT; also flags wrong products and hung operations.

Parameters:
- DATA_W, 4, operand width (data_in width).
- PROD_W, 8, product width; fixed at 2*DATA_W.
- TIMEOUT, 64, max cycles in WAIT_DONE before an operation is abandoned; legal range 2..255.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request operand pair valid.
- req_ready  output  1  block can accept a request.
- req_a  input  DATA_W  multiplicand.
- req_b  input  DATA_W  multiplier.
- start  output  1  to multiplier; one-cycle pulse marking operand A.
- data_in  output  DATA_W  to multiplier; A in the start cycle, B the next cycle.
- done  input  1  from multiplier; one-cycle pulse, result valid in the same cycle.
- result  input  PROD_W  from multiplier product.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_prod  output  PROD_W  captured product (0 on timeout).
- rsp_mismatch  output  1  captured product != req_a*req_b.
- rsp_timeout  output  1  done not seen within TIMEOUT cycles.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; start=0, data_in=0, req_ready=0, rsp_valid=0, rsp_prod=0, rsp_mismatch=0, rsp_timeout=0; wait counter=0; operand registers=0.
- Reset asserted mid-operation aborts it. No response is produced for the aborted operation.
- Reset deassertion takes effect at the next clock edge.
- FSM states: IDLE, SEND_A, SEND_B, WAIT_DONE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch a,b and go to SEND_A.
- SEND_A (exactly 1 cycle): start=1, data_in=a. Next state is SEND_B.
- SEND_B (exactly 1 cycle):
  - start=0, data_in=b.
  - Counter cleared.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - start=0, data_in=0; counter increments every cycle.
  - done=1: capture result into rsp_prod.
  - Set rsp_mismatch=(result != a*b), computed at PROD_W width, unsigned.
  - Set rsp_timeout=0 and go to RESP.
  - If counter reaches TIMEOUT-1 without done: rsp_prod=0, rsp_timeout=1, rsp_mismatch=0, go to RESP.
  - done and the timeout boundary in the same cycle: done wins.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle, state returns to IDLE.
- Latency (done at cycle N of WAIT_DONE, N>=1):
  - Request accept cycle = 0.
  - start high at cycle 1; B driven at cycle 2.
  - rsp_valid rises the cycle after done.
- Throughput: one request in flight. req_ready=0 outside IDLE, so no back-to-back requests are accepted while busy.
- A done pulse outside WAIT_DONE (spurious) is ignored and does not change state.
- Full operand range 0..15 is legal, including 0 and 15 (15*15=225).
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package mult_pkg holds:
  - DATA_W/PROD_W constants;
  - typedef enum logic[2:0] for issuer states {IDLE, SEND_A, SEND_B, WAIT_DONE, RESP};
  - typedef struct for the response {prod, mismatch, timeout}.
- Package is shared with the multiplier interface, bench driver and monitor.
- No sub-module needed; the timeout counter stays inline in the FSM.

Test Plan:
- a=3,b=5, multiplier returns done with result=15 after 4 cycles: start=1 with data_in=3 then data_in=5; rsp_prod=15, mismatch=0, timeout=0; rsp_valid one cycle after done.
- a=15,b=15, result=225: rsp_prod=225, no flags. a=0,b=9, result=0: rsp_prod=0, no flags.
- a=4,b=4, result=17 injected: rsp_prod=17, rsp_mismatch=1.
- Done never asserted, TIMEOUT=64: rsp_valid rises 64 cycles after SEND_B with rsp_timeout=1 and rsp_prod=0. Then a new request completes normally.
- rsp_ready held low 10 cycles: outputs stable, req_ready=0 throughout. A req_valid during this window is not accepted until after the handshake and return to IDLE.
- Reset pulled low during WAIT_DONE: all outputs 0 immediately (asynchronous). Late done is ignored; no response is emitted; the next request works normally.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, issuer state encoding and response record for the 4-bit multiplier protocol
package mult_pkg;
  localparam int DATA_W = 4;
  localparam int PROD_W = 2 * DATA_W;
  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_DONE, RESP} issuer_state_e;
  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic              mismatch;
    logic              timeout;
  } rsp_t;
endpackage

// File: rtl/mult_req_issuer.sv
// mult_req_issuer: takes req_a/req_b on valid/ready, drives start/data_in, waits for done/result, returns rsp_prod/rsp_mismatch/rsp_timeout on valid/ready
module mult_req_issuer #(
  parameter int DATA_W  = mult_pkg::DATA_W,
  parameter int PROD_W  = mult_pkg::PROD_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              start,
  output logic [DATA_W-1:0] data_in,
  input  logic              done,
  input  logic [PROD_W-1:0] result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_prod,
  output logic              rsp_mismatch,
  output logic              rsp_timeout
);
  import mult_pkg::*;
  issuer_state_e     state;
  logic [DATA_W-1:0] a, b;
  logic [7:0]        cnt;
  logic [PROD_W-1:0] exp_prod;
  assign exp_prod = PROD_W'(a) * PROD_W'(b);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      cnt          <= '0;
      req_ready    <= 1'b0;
      start        <= 1'b0;
      data_in      <= '0;
      rsp_valid    <= 1'b0;
      rsp_prod     <= '0;
      rsp_mismatch <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            a         <= req_a;
            b         <= req_b;
            req_ready <= 1'b0;
            start     <= 1'b1;
            data_in   <= req_a;
            state     <= SEND_A;
          end else
            req_ready <= 1'b1;
        SEND_A: begin
          start   <= 1'b0;
          data_in <= b;
          state   <= SEND_B;
        end
        SEND_B: begin
          data_in <= '0;
          cnt     <= '0;
          state   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + 8'd1;
          if (done) begin
            rsp_prod     <= result;
            rsp_mismatch <= result != exp_prod;
            rsp_timeout  <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (cnt == 8'(TIMEOUT - 2)) begin
            rsp_prod     <= '0;
            rsp_mismatch <= 1'b0;
            rsp_timeout  <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mult_req_issuer.sv
// tb_mult_req_issuer: table-driven directed checks of the issuer with a scripted multiplier
module tb_mult_req_issuer;
  import mult_pkg::*;
  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_a = '0;
  logic [DATA_W-1:0] req_b = '0;
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              done = 1'b0;
  logic [PROD_W-1:0] result = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [PROD_W-1:0] rsp_prod;
  logic              rsp_mismatch;
  logic              rsp_timeout;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int a, b, n, res, hold, prod, mm, to, lat;
  } vec_t;
  vec_t v[8];
  mult_req_issuer #(.DATA_W(DATA_W), .PROD_W(PROD_W), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .start(start), .data_in(data_in), .done(done), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod),
    .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input vec_t t);
    int c;
    c = 0;
    while (!req_ready && c < 20) begin
      @(negedge clock);
      c++;
    end
    chk("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_a = DATA_W'(t.a);
    req_b = DATA_W'(t.b);
    @(negedge clock);
    req_valid = 1'b0;
    chk("send_a_start", int'(start), 1);
    chk("send_a_data", int'(data_in), t.a);
    chk("send_a_req_ready", int'(req_ready), 0);
    @(negedge clock);
    chk("send_b_start", int'(start), 0);
    chk("send_b_data", int'(data_in), t.b);
    c = 0;
    while (c < 300) begin
      @(negedge clock);
      c++;
      done = 1'b0;
      if (rsp_valid) break;
      if (c == t.n) begin
        done = 1'b1;
        result = PROD_W'(t.res);
      end
    end
    chk("rsp_latency", c, t.lat);
    chk("rsp_prod", int'(rsp_prod), t.prod);
    chk("rsp_mismatch", int'(rsp_mismatch), t.mm);
    chk("rsp_timeout", int'(rsp_timeout), t.to);
    chk("resp_req_ready", int'(req_ready), 0);
    for (int i = 0; i < t.hold; i++) begin
      if (i == 2) begin
        req_valid = 1'b1;
        req_a = 4'd1;
        req_b = 4'd1;
      end
      @(negedge clock);
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_prod", int'(rsp_prod), t.prod);
      chk("hold_req_ready", int'(req_ready), 0);
      chk("hold_start", int'(start), 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("post_hs_valid", int'(rsp_valid), 0);
    chk("post_hs_req_ready", int'(req_ready), 1);
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_data_in"}, int'(data_in), 0);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_prod"}, int'(rsp_prod), 0);
    chk({tag, "_rsp_mismatch"}, int'(rsp_mismatch), 0);
    chk({tag, "_rsp_timeout"}, int'(rsp_timeout), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{3, 5, 4, 15, 0, 15, 0, 0, 5};
    v[1] = '{15, 15, 2, 225, 0, 225, 0, 0, 3};
    v[2] = '{0, 9, 1, 0, 0, 0, 0, 0, 2};
    v[3] = '{4, 4, 3, 17, 0, 17, 1, 0, 4};
    v[4] = '{7, 6, 0, 0, 0, 0, 0, 1, 64};
    v[5] = '{2, 3, 5, 6, 10, 6, 0, 0, 6};
    v[6] = '{9, 9, 63, 81, 0, 81, 0, 0, 64};
    v[7] = '{15, 15, 1, 224, 0, 224, 1, 0, 2};
    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clock);
    chk("reset_hold_req_ready", int'(req_ready), 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) run(v[i]);
    req_valid = 1'b1;
    req_a = 4'd5;
    req_b = 4'd5;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b1;
    done = 1'b1;
    result = 8'd25;
    @(negedge clock);
    done = 1'b0;
    chk("spurious_req_ready", int'(req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("spurious_no_rsp", int'(rsp_valid), 0);
      chk("spurious_no_start", int'(start), 0);
    end
    run('{6, 7, 2, 42, 0, 42, 0, 0, 3});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
